// File: rtl/tppe_fiber_sram_arbiter_pkg.sv
// Shared types and SRAM geometry for the fiber_A read-port arbiter.
// The lane id type is sized for the default four-lane configuration.
package tppe_pkg;

  localparam int ADDR_W  = 10;
  localparam int DATA_W  = 32;
  localparam int NUM_REQ = 4;

  typedef logic [$clog2(NUM_REQ)-1:0] lane_id_t;

  typedef enum logic [0:0] {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/tppe_fiber_sram_arbiter_rr_pick.sv
// Combinational round-robin picker: the first set request at or above ptr_i,
// wrapping modulo N, returned both as a one-hot grant and as an index.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);

  logic [IW-1:0] cand;
  logic          found;

  // Scan from the farthest offset down so the nearest request is written last.
  always_comb begin
    gnt_o = '0;
    idx_o = ptr_i;
    cand  = ptr_i;
    found = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = ptr_i + IW'(k);
      if (req_i[cand]) begin
        idx_o = cand;
        found = 1'b1;
      end
    end
    if (found) gnt_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/tppe_fiber_sram_arbiter.sv
// Shares the fiber_A SRAM read port between NUM_REQ TPPE lanes with
// round-robin arbitration, capped locked bursts and a fixed-latency return path.
module tppe_fiber_sram_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_W    = tppe_pkg::ADDR_W,
  parameter int DATA_W    = tppe_pkg::DATA_W,
  parameter int SRAM_LAT  = 1,
  parameter int MAX_BURST = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ-1:0]             req_lock,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [DATA_W-1:0]              rsp_data,
  output logic [ADDR_W-1:0]              sram_raddr,
  input  logic [DATA_W-1:0]              sram_rdata,
  output logic                           busy
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST) + 1;
  localparam int DEPTH = 1 + SRAM_LAT;

  tppe_pkg::arb_state_e           state_q;
  logic [IDX_W-1:0]               rr_ptr_q;
  logic [IDX_W-1:0]               owner_q;
  logic [CNT_W-1:0]               burst_cnt_q;
  logic [CNT_W-1:0]               burst_cnt_d;
  logic [ADDR_W-1:0]              sram_raddr_q;
  logic [DEPTH-1:0]               pipe_v_q;
  logic [DEPTH-1:0][IDX_W-1:0]    pipe_id_q;

  logic [NUM_REQ-1:0] pick_gnt;
  logic [IDX_W-1:0]   pick_idx;
  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic               beat;

  rr_pick #(.N(NUM_REQ)) u_rr_pick (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx)
  );

  // While locked only the owner can be granted; the picker is bypassed.
  always_comb begin
    gnt     = '0;
    gnt_idx = pick_idx;
    if (rst_n) begin
      if (state_q == tppe_pkg::LOCKED) begin
        gnt_idx = owner_q;
        if (req_valid[owner_q]) gnt[owner_q] = 1'b1;
      end else begin
        gnt = pick_gnt;
      end
    end
  end

  assign beat        = |gnt;
  assign req_ready   = gnt;
  assign burst_cnt_d = (burst_cnt_q >= CNT_W'(MAX_BURST)) ? burst_cnt_q
                                                          : burst_cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= tppe_pkg::ARB;
      rr_ptr_q     <= '0;
      owner_q      <= '0;
      burst_cnt_q  <= '0;
      sram_raddr_q <= '0;
      pipe_v_q     <= '0;
      pipe_id_q    <= '0;
    end else begin
      if (beat) sram_raddr_q <= req_addr[gnt_idx];
      pipe_v_q[0]  <= beat;
      pipe_id_q[0] <= gnt_idx;
      for (int k = 1; k < DEPTH; k++) begin
        pipe_v_q[k]  <= pipe_v_q[k-1];
        pipe_id_q[k] <= pipe_id_q[k-1];
      end
      case (state_q)
        tppe_pkg::ARB: begin
          if (beat) begin
            if (req_lock[gnt_idx] && (MAX_BURST > 1)) begin
              state_q     <= tppe_pkg::LOCKED;
              owner_q     <= gnt_idx;
              burst_cnt_q <= CNT_W'(1);
            end else begin
              rr_ptr_q <= gnt_idx + 1'b1;
            end
          end
        end
        tppe_pkg::LOCKED: begin
          if (!beat) begin
            state_q  <= tppe_pkg::ARB;
            rr_ptr_q <= owner_q + 1'b1;
          end else begin
            burst_cnt_q <= burst_cnt_d;
            if (!req_lock[owner_q] || (burst_cnt_d >= CNT_W'(MAX_BURST))) begin
              state_q  <= tppe_pkg::ARB;
              rr_ptr_q <= owner_q + 1'b1;
            end
          end
        end
        default: state_q <= tppe_pkg::ARB;
      endcase
    end
  end

  always_comb begin
    rsp_valid = '0;
    if (pipe_v_q[DEPTH-1]) rsp_valid[pipe_id_q[DEPTH-1]] = 1'b1;
  end

  assign rsp_data   = sram_rdata;
  assign sram_raddr = sram_raddr_q;
  assign busy       = (|pipe_v_q) || (state_q == tppe_pkg::LOCKED);

endmodule

// File: tb/tb_tppe_fiber_sram_arbiter.sv
// Randomized and directed bench for the fiber_A read-port arbiter, checked
// against a scheduling model of grants, bursts and in-flight responses.
module tb_tppe_fiber_sram_arbiter;
  import tppe_pkg::*;

  localparam int N    = 4;
  localparam int AW   = 10;
  localparam int DW   = 32;
  localparam int MAXB = 8;
  localparam int LAT  = 1;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [N-1:0]           req_valid;
  logic [N-1:0][AW-1:0]   req_addr;
  logic [N-1:0]           req_lock;
  logic [N-1:0]           req_ready;
  logic [N-1:0]           rsp_valid;
  logic [DW-1:0]          rsp_data;
  logic [AW-1:0]          sram_raddr;
  logic [DW-1:0]          sram_rdata;
  logic                   busy;

  always #5 clk = ~clk;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) sram_rdata <= mem[sram_raddr];

  tppe_fiber_sram_arbiter #(
    .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .SRAM_LAT(LAT), .MAX_BURST(MAXB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_lock(req_lock), .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .sram_raddr(sram_raddr), .sram_rdata(sram_rdata),
    .busy(busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int           due;
    int           lane;
    logic [AW-1:0] addr;
  } pend_t;

  pend_t         pend[$];
  bit            m_locked = 0;
  int            m_owner  = 0;
  int            m_ptr    = 0;
  int            m_cnt    = 0;
  logic [AW-1:0] m_raddr  = '0;
  int            cyc      = 0;

  // One clock cycle: drive at the falling edge, check 1 ns later, then
  // advance the model to what the next rising edge should produce.
  task automatic step(input logic rstn, input logic [N-1:0] v,
                      input logic [N-1:0] lk, input int fa);
    int            g;
    logic [63:0]   exp_rdy;
    logic [63:0]   exp_rv;
    logic [DW-1:0] exp_d;
    bit            have;
    @(negedge clk);
    rst_n     = rstn;
    req_valid = v;
    req_lock  = lk;
    for (int i = 0; i < N; i++)
      req_addr[i] = (fa < 0) ? AW'($urandom) : AW'(fa);
    #1;
    g = -1;
    if (rstn) begin
      if (m_locked) begin
        if (v[m_owner]) g = m_owner;
      end else begin
        for (int k = N - 1; k >= 0; k--)
          if (v[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      end
    end
    exp_rdy = (g < 0) ? 64'd0 : (64'd1 << g);
    check_val("req_ready", 64'(req_ready), exp_rdy);
    check_val("sram_raddr", 64'(sram_raddr), 64'(m_raddr));
    check_val("busy", 64'(busy), 64'((pend.size() > 0) || m_locked));
    exp_rv = '0;
    exp_d  = '0;
    have   = 0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      exp_rv = 64'd1 << pend[0].lane;
      exp_d  = mem[pend[0].addr];
      have   = 1;
      void'(pend.pop_front());
    end
    check_val("rsp_valid", 64'(rsp_valid), exp_rv);
    if (have) check_val("rsp_data", 64'(rsp_data), 64'(exp_d));
    if (g >= 0)
      $display("cyc %0d: grant lane %0d addr 0x%03h lock %0d", cyc, g, req_addr[g], lk[g]);
    if (!rstn) begin
      m_locked = 0; m_ptr = 0; m_cnt = 0; m_raddr = '0;
      pend.delete();
    end else begin
      if (g >= 0) begin
        m_raddr = req_addr[g];
        pend.push_back('{due: cyc + 1 + LAT, lane: g, addr: req_addr[g]});
      end
      if (m_locked) begin
        if (g < 0) begin
          m_locked = 0;
          m_ptr    = (m_owner + 1) % N;
        end else begin
          if (m_cnt < MAXB) m_cnt++;
          if (!lk[m_owner] || m_cnt >= MAXB) begin
            m_locked = 0;
            m_ptr    = (m_owner + 1) % N;
          end
        end
      end else if (g >= 0) begin
        if (lk[g]) begin
          m_locked = 1; m_owner = g; m_cnt = 1;
        end else begin
          m_ptr = (g + 1) % N;
        end
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, '0, '0, -1);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;
    mem[10'h015] = 32'hA5A5_0001;
    rst_n = 1'b0; req_valid = '0; req_lock = '0; req_addr = '0;
    repeat (2) @(posedge clk);

    // Reset state, then a single lane-2 read.
    step(1'b0, '0, '0, -1);
    step(1'b1, 4'b0100, 4'b0000, 10'h015);
    idle(3);

    // Fairness from reset.
    step(1'b0, '0, '0, -1);
    for (int i = 0; i < 8; i++) step(1'b1, 4'b1111, 4'b0000, -1);
    idle(3);

    // Lane 1 holds a four-beat locked burst against lanes 0 and 3.
    step(1'b0, '0, '0, -1);
    step(1'b1, 4'b0010, 4'b0010, -1);
    step(1'b1, 4'b1011, 4'b0010, -1);
    step(1'b1, 4'b1011, 4'b0010, -1);
    step(1'b1, 4'b1011, 4'b0000, -1);
    step(1'b1, 4'b1001, 4'b0000, -1);
    step(1'b1, 4'b1001, 4'b0000, -1);
    idle(3);

    // Burst cap with lane 0 locking indefinitely.
    step(1'b0, '0, '0, -1);
    for (int i = 0; i < 12; i++) step(1'b1, 4'b0101, 4'b0001, -1);
    idle(3);

    // Locked owner drops its request for one cycle.
    step(1'b0, '0, '0, -1);
    step(1'b1, 4'b1000, 4'b1000, -1);
    step(1'b1, 4'b1000, 4'b1000, -1);
    step(1'b1, 4'b0110, 4'b1000, -1);
    step(1'b1, 4'b0110, 4'b0000, -1);
    idle(3);

    // Reset on the cycle after a beat.
    step(1'b1, 4'b0100, 4'b0000, -1);
    step(1'b0, 4'b1111, 4'b0000, -1);
    step(1'b1, 4'b1111, 4'b0000, -1);
    idle(3);

    for (int i = 0; i < 3000; i++)
      step(($urandom_range(0, 99) != 0), N'($urandom), N'($urandom | $urandom), -1);
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tppe_fiber_sram_arbiter.md
Name: tppe_fiber_sram_arbiter

Overview:
- Shares the single read port of the fiber_A SRAM (10-bit address, 32-bit data) between NUM_REQ TPPE lanes.
- Each lane issues word-read requests over a valid/ready handshake; the block arbitrates round-robin, with an optional locked-burst mode.
- Drives the SRAM read address and returns read data to the winning lane after a fixed latency.
- Sits between the TPPE array and the fiber_A SRAM instance.

Parameters:
- NUM_REQ, 4, number of requesting TPPE lanes (power of two, at least 2).
- ADDR_W, 10, SRAM read address width.
- DATA_W, 32, SRAM read data width.
- SRAM_LAT, 1, cycles from sram_raddr update to valid sram_rdata (0 = combinational read).
- MAX_BURST, 8, maximum consecutive grants a lane may hold in LOCKED.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  NUM_REQ  per-lane read request valid.
- req_addr  in  NUM_REQ x ADDR_W  per-lane read address.
- req_lock  in  NUM_REQ  per-lane request to keep the grant after this beat.
- req_ready  out  NUM_REQ  per-lane grant, one-hot or zero, combinational.
- rsp_valid  out  NUM_REQ  per-lane read data valid, one-hot or zero.
- rsp_data  out  DATA_W  read data, broadcast to all lanes; qualified by rsp_valid.
- sram_raddr  out  ADDR_W  to SRAM ReadAddress1, registered.
- sram_rdata  in  DATA_W  from SRAM ReadBus1.
- busy  out  1  high while any response is in flight or state is LOCKED.

Behaviour:
- Reset (rst_n low at a clock edge):
  - state=ARB, rr_ptr=0, burst_cnt=0, response pipeline cleared.
  - sram_raddr=0, rsp_valid=0, busy=0.
  - req_ready=0 while rst_n is low.
- Handshake:
  - A beat is transferred when req_valid[i] and req_ready[i] are both high in the same cycle.
  - req_ready depends on req_valid, state, rr_ptr and owner only; never on req_addr.
  - A lane may not withdraw req_valid before the handshake; no check is made, and a withdrawn request is simply not granted.
- State ARB:
  - Grant the first lane with req_valid high, scanning from rr_ptr upward modulo NUM_REQ.
  - On a grant to g: rr_ptr <= (g+1) mod NUM_REQ.
  - If req_lock[g]=1 on that beat: owner <= g, burst_cnt <= 1, go to LOCKED, and rr_ptr is not updated yet.
  - No valid requests: no grant, no state change.
- State LOCKED:
  - req_ready is asserted only to the owner, and only when req_valid[owner]=1.
  - Each owner beat increments burst_cnt.
  - Release to ARB with rr_ptr <= owner+1 on any of:
    - (a) an owner beat with req_lock=0;
    - (b) an owner beat that makes burst_cnt reach MAX_BURST, regardless of req_lock;
    - (c) a cycle with req_valid[owner]=0, in which case nothing is granted that cycle.
  - Release takes effect from the next cycle.
- SRAM addressing:
  - On a beat in cycle t, sram_raddr <= granted req_addr at the edge ending t.
  - With no beat, sram_raddr holds its value.
- Response:
  - A shift register of depth 1+SRAM_LAT carries {valid, lane id}.
  - rsp_valid[id] rises exactly 1+SRAM_LAT cycles after the beat cycle: cycle t+2 for SRAM_LAT=1.
  - rsp_data = sram_rdata, passed combinationally.
- Throughput:
  - One beat per cycle total.
  - Back-to-back beats yield back-to-back responses in grant order.
  - No response backpressure: lanes must accept rsp_valid unconditionally.
- Arithmetic: rr_ptr wraps modulo NUM_REQ; burst_cnt is clog2(MAX_BURST)+1 bits wide and saturates, never wrapping.
- Reset mid-operation: in-flight responses are dropped (no rsp_valid), a LOCKED owner loses its lock, and rr_ptr returns to 0.
- busy = OR of pipeline valid bits, OR state==LOCKED.

Decomposition:
- Shared package tppe_pkg holds:
  - a typedef for the lane id (clog2(NUM_REQ) bits);
  - a typedef for the arbiter state enum {ARB, LOCKED};
  - the SRAM constants ADDR_W=10 and DATA_W=32.
- One sub-module, rr_pick, is natural: combinational NUM_REQ-way round-robin priority picker taking a request vector and a pointer and returning a one-hot grant plus an index.
- FSM, burst counter and response pipeline stay in the top.

Test Plan:
- Single request: lane 2 valid with addr 0x015, SRAM preloaded 0x015=0xA5A5_0001 -> req_ready[2] in the same cycle, sram_raddr=0x015 next cycle, rsp_valid=4'b0100 with rsp_data=0xA5A5_0001 two cycles after the beat (SRAM_LAT=1).
- Fairness: all four lanes valid continuously for 8 cycles from reset -> grant sequence 0,1,2,3,0,1,2,3; responses arrive in the same order, 2 cycles delayed.
- Lock: lane 1 with req_lock=1 for 3 beats then lock=0 while lanes 0 and 3 are valid -> lane 1 gets 4 consecutive grants, then lane 3, then lane 0.
- Burst cap: lane 0 holds req_lock=1 indefinitely with lane 2 valid, MAX_BURST=8 -> exactly 8 consecutive lane-0 grants, then lane 2 is granted.
- Owner drop: lane 3 locked, deasserts req_valid for one cycle -> no grant in that cycle, state returns to ARB, and the next grant goes to the first valid lane from 0.
- Reset mid-flight: assert rst_n=0 on the cycle after a beat -> no rsp_valid ever rises for that beat, sram_raddr=0, busy=0, and the first post-reset grant favours lane 0.
